// File: rtl/stage_wb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_wb: MEM/WB pipeline register and register-file write port driver.  |
// | Optional macro WB_BYPASS_EN: forward the write-back value to ID reads.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stage_wb #(
  parameter int data_width = 32,
  parameter int reg_addr   = 3,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic                  mem_WRegEn,
  input  logic                  mem_isMemInst,
  input  logic [reg_addr-1:0]   mem_wReg1,
  input  logic [data_width-1:0] mem_alu_result,
  input  logic [data_width-1:0] mem_rdata,
  input  logic [reg_addr-1:0]   id_r1addr,
  input  logic [reg_addr-1:0]   id_r2addr,
  input  logic [data_width-1:0] id_r1data_in,
  input  logic [data_width-1:0] id_r2data_in,
  output logic                  WRegEn_out,
  output logic [reg_addr-1:0]   wReg1_out,
  output logic [data_width-1:0] wdata_out,
  output logic                  wb_valid,
  output logic [31:0]           retire_cnt,
  output logic [data_width-1:0] r1_fwd,
  output logic [data_width-1:0] r2_fwd
);

  logic                  valid_q, valid_d;
  logic                  wen_q, wen_d;
  logic [reg_addr-1:0]   wreg_q, wreg_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  fire;

  // done marks an entry already written, so a stalled entry writes only once
  assign fire = valid_q & ~done_q;

  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    wreg_d  = wreg_q;
    data_d  = data_q;
    done_d  = done_q;
    cnt_d   = cnt_q + {31'd0, fire};
    if (flush) begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else if (stall) begin
      if (valid_q) done_d = 1'b1;
    end else begin
      valid_d = mem_valid;
      wen_d   = mem_WRegEn;
      wreg_d  = mem_wReg1;
      data_d  = mem_isMemInst ? mem_rdata : mem_alu_result;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      wreg_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      wreg_q  <= wreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign WRegEn_out = fire & wen_q & ~(ZERO_REG && (wreg_q == '0));
  assign wReg1_out  = wreg_q;
  assign wdata_out  = data_q;
  assign wb_valid   = valid_q;
  assign retire_cnt = cnt_q;

`ifdef WB_BYPASS_EN
  assign r1_fwd = (WRegEn_out && (wReg1_out == id_r1addr)) ? wdata_out : id_r1data_in;
  assign r2_fwd = (WRegEn_out && (wReg1_out == id_r2addr)) ? wdata_out : id_r2data_in;
`else
  logic unused_id_addr;
  assign unused_id_addr = ^{id_r1addr, id_r2addr};
  assign r1_fwd = id_r1data_in;
  assign r2_fwd = id_r2data_in;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage_wb.sv
`default_nettype none
// Directed self-checking bench for stage_wb (default parameters).
module tb_stage_wb;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, mem_valid, mem_WRegEn, mem_isMemInst;
  logic [2:0]  mem_wReg1, id_r1addr, id_r2addr;
  logic [31:0] mem_alu_result, mem_rdata, id_r1data_in, id_r2data_in;
  logic        WRegEn_out, wb_valid;
  logic [2:0]  wReg1_out;
  logic [31:0] wdata_out, retire_cnt, r1_fwd, r2_fwd;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  stage_wb dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_WRegEn(mem_WRegEn), .mem_isMemInst(mem_isMemInst),
    .mem_wReg1(mem_wReg1), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
    .id_r1addr(id_r1addr), .id_r2addr(id_r2addr),
    .id_r1data_in(id_r1data_in), .id_r2data_in(id_r2data_in),
    .WRegEn_out(WRegEn_out), .wReg1_out(wReg1_out), .wdata_out(wdata_out),
    .wb_valid(wb_valid), .retire_cnt(retire_cnt), .r1_fwd(r1_fwd), .r2_fwd(r2_fwd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic ld, input logic [2:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdat);
    mem_valid = v; mem_WRegEn = we; mem_isMemInst = ld;
    mem_wReg1 = rd; mem_alu_result = alu; mem_rdata = rdat;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    id_r1addr = 3'd0; id_r2addr = 3'd0; id_r1data_in = '0; id_r2data_in = '0;
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'hFFFF_0000, 32'h1111_2222);

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, $urandom_range(0, 1) == 1, 3'($urandom_range(1, 7)), $urandom, $urandom);
      stall = $urandom_range(0, 1) == 1;
      tick();
    end
    check("rst_wen", {31'd0, WRegEn_out}, 32'd0);
    check("rst_wreg", {29'd0, wReg1_out}, 32'd0);
    check("rst_wdata", wdata_out, 32'd0);
    check("rst_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    rst_n = 1'b1; stall = 1'b0;
    exp_cnt = 32'd0;

    // ALU write-back
    drive(1'b1, 1'b1, 1'b0, 3'd3, 32'h0000_1234, 32'hCAFE_0000);
    tick();
    check("alu_wen", {31'd0, WRegEn_out}, 32'd1);
    check("alu_wreg", {29'd0, wReg1_out}, 32'd3);
    check("alu_wdata", wdata_out, 32'h0000_1234);
    drive(1'b0, 1'b1, 1'b0, 3'd7, 32'h9999_9999, 32'h8888_8888);
    tick();
    exp_cnt = exp_cnt + 1;
    check("alu_cnt", retire_cnt, exp_cnt);
    check("bubble_wen", {31'd0, WRegEn_out}, 32'd0);

    // load write-back
    drive(1'b1, 1'b1, 1'b1, 3'd5, 32'h0000_0010, 32'hDEAD_BEEF);
    tick();
    check("ld_wen", {31'd0, WRegEn_out}, 32'd1);
    check("ld_wdata", wdata_out, 32'hDEAD_BEEF);
    check("ld_wreg", {29'd0, wReg1_out}, 32'd5);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    exp_cnt = exp_cnt + 1;
    check("bubble_cnt", retire_cnt, exp_cnt);

    // stall: one write, held data, one count
    drive(1'b1, 1'b1, 1'b0, 3'd6, 32'h0000_AAAA, 32'h0);
    tick();
    check("stl_wen0", {31'd0, WRegEn_out}, 32'd1);
    stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd1, 32'h0000_5555, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stl_wen", {31'd0, WRegEn_out}, 32'd0);
      check("stl_wdata", wdata_out, 32'h0000_AAAA);
      check("stl_valid", {31'd0, wb_valid}, 32'd1);
    end
    exp_cnt = exp_cnt + 1;
    check("stl_cnt", retire_cnt, exp_cnt);

    // flush wins over stall
    flush = 1'b1;
    tick();
    check("fl_valid", {31'd0, wb_valid}, 32'd0);
    check("fl_wen", {31'd0, WRegEn_out}, 32'd0);
    check("fl_cnt", retire_cnt, exp_cnt);
    flush = 1'b0; stall = 1'b0;

    // write to r0 suppressed but retired
    drive(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_0042, 32'h0);
    tick();
    check("r0_wen", {31'd0, WRegEn_out}, 32'd0);
    check("r0_valid", {31'd0, wb_valid}, 32'd1);
    // non-writing instruction still retires
    drive(1'b1, 1'b0, 1'b0, 3'd4, 32'h0000_0043, 32'h0);
    tick();
    exp_cnt = exp_cnt + 1;
    check("r0_cnt", retire_cnt, exp_cnt);
    check("nw_wen", {31'd0, WRegEn_out}, 32'd0);

    // ID read bypass
    drive(1'b1, 1'b1, 1'b0, 3'd3, 32'h0000_1234, 32'h0);
    tick();
    exp_cnt = exp_cnt + 1;
    id_r1addr = 3'd3; id_r1data_in = 32'h0;
    id_r2addr = 3'd4; id_r2data_in = 32'h0000_0077;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_r1", r1_fwd, 32'h0000_1234);
`else
    check("byp_r1", r1_fwd, 32'h0);
`endif
    check("byp_r2", r2_fwd, 32'h0000_0077);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    exp_cnt = exp_cnt + 1;
    check("end_cnt", retire_cnt, exp_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
